// File: rtl/vm_irq_ctrl_if.sv
// Vector-acknowledge handshake between the CPU and the interrupt controller.
//   virq : controller -> CPU, vectored interrupt request
//   istb : CPU -> controller, vector read strobe
//   ivec : controller -> CPU, 16-bit vector (zero while iack is low)
//   iack : controller -> CPU, vector acknowledge
// master = CPU side, slave = controller side.
interface vm_irq_ctrl_if;
  logic        virq;
  logic        istb;
  logic [15:0] ivec;
  logic        iack;

  modport master (input virq, input ivec, input iack, output istb);
  modport slave  (output virq, output ivec, output iack, input istb);
endinterface

// File: rtl/vm_irq_ctrl.sv
// Vectored interrupt controller: collects N peripheral requests, raises virq,
// and answers the CPU's istb strobe with the vector of the highest-priority
// pending channel (channel 0 highest), then pulses irq_done to the winner.
// Ports:
//   clk_p     : system clock, rising edge
//   rst       : synchronous active-high reset
//   irq_req   : level requests from peripherals [N]
//   irq_done  : one-cycle pulse to the channel whose vector was delivered [N]
//   active_ch : channel latched for the current/last service (debug) [3]
//   bus       : virq/istb/ivec/iack handshake (slave side)
// Optional feature: define IRQ_EDGE_EN to capture rising edges of irq_req in
// per-channel pending bits instead of using the raw request levels.
module vm_irq_ctrl #(
  parameter int unsigned          N         = 4,
  parameter logic [N*16-1:0]      VECTORS   = {16'o104, 16'o070, 16'o064, 16'o060},
  parameter int unsigned          ACK_DELAY = 1,
  parameter logic [15:0]          SPUR_VEC  = 16'o000
) (
  input  logic                clk_p,
  input  logic                rst,
  input  logic [N-1:0]        irq_req,
  output logic [N-1:0]        irq_done,
  output logic [2:0]          active_ch,
  vm_irq_ctrl_if.slave        bus
);

  localparam int unsigned CW   = 3;
  localparam int unsigned CNTW = 3;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DRIVE   = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            virq_q,  virq_d;
  logic            iack_q,  iack_d;
  logic [15:0]     ivec_q,  ivec_d;
  logic [N-1:0]    done_q,  done_d;
  logic [CW-1:0]   win_q,   win_d;
  logic            spur_q,  spur_d;
  logic [CNTW-1:0] cnt_q,   cnt_d;

  logic [N-1:0]    eff;
  logic [CW-1:0]   win_c;
  logic            any_c;
  logic [15:0]     vec_sel;
  logic [N-1:0]    win_onehot;

`ifdef IRQ_EDGE_EN
  logic [N-1:0] req_prev_q;
  logic [N-1:0] pend_q, pend_d;

  // New edge is OR-ed in after the clear so a same-cycle set wins.
  always_comb begin
    pend_d = (pend_q & ~done_q) | (irq_req & ~req_prev_q);
  end

  always_ff @(posedge clk_p) begin
    if (rst) begin
      req_prev_q <= '0;
      pend_q     <= '0;
    end else begin
      req_prev_q <= irq_req;
      pend_q     <= pend_d;
    end
  end

  assign eff = pend_q;
`else
  assign eff = irq_req;
`endif

  // Fixed priority: lowest set index wins.
  always_comb begin
    win_c = '0;
    any_c = |eff;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (eff[i]) win_c = CW'(i);
    end
  end

  // Vector and done pulse for the latched winner.
  always_comb begin
    vec_sel    = '0;
    win_onehot = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (CW'(i) == win_q) begin
        vec_sel       = VECTORS[16*i +: 16];
        win_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    virq_d  = virq_q;
    iack_d  = iack_q;
    ivec_d  = ivec_q;
    done_d  = '0;
    win_d   = win_q;
    spur_d  = spur_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        virq_d = |eff;
        if (bus.istb) begin
          virq_d  = 1'b0;
          win_d   = any_c ? win_c : '0;
          spur_d  = ~any_c;
          cnt_d   = CNTW'(ACK_DELAY);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A strobe that falls before the vector is driven aborts the cycle.
        if (!bus.istb) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          iack_d  = 1'b1;
          ivec_d  = spur_q ? SPUR_VEC : vec_sel;
          state_d = S_DRIVE;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      S_DRIVE: begin
        if (!bus.istb) begin
          iack_d  = 1'b0;
          ivec_d  = '0;
          done_d  = spur_q ? '0 : win_onehot;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Guard cycle so the peripheral can drop its request.
        virq_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_p) begin
    if (rst) begin
      state_q <= S_IDLE;
      virq_q  <= 1'b0;
      iack_q  <= 1'b0;
      ivec_q  <= '0;
      done_q  <= '0;
      win_q   <= '0;
      spur_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      virq_q  <= virq_d;
      iack_q  <= iack_d;
      ivec_q  <= ivec_d;
      done_q  <= done_d;
      win_q   <= win_d;
      spur_q  <= spur_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.virq  = virq_q;
  assign bus.iack  = iack_q;
  assign bus.ivec  = ivec_q;
  assign irq_done  = done_q;
  assign active_ch = win_q;

endmodule

// File: tb/tb_vm_irq_ctrl.sv
// Bench for vm_irq_ctrl: a table of per-cycle vectors on the default
// instance plus hand-written abort/latency sequences on an ACK_DELAY=3
// instance (edge-capture sequence when IRQ_EDGE_EN is defined).
module tb_vm_irq_ctrl;

  logic       clk_p = 1'b0;
  logic       rst_a, rst_b;
  logic [3:0] req_a, req_b;
  logic [3:0] done_a, done_b;
  logic [2:0] ac_a, ac_b;

  int checks   = 0;
  int failures = 0;

  vm_irq_ctrl_if bus_a ();
  vm_irq_ctrl_if bus_b ();

  vm_irq_ctrl u_dut_a (
    .clk_p     (clk_p),
    .rst       (rst_a),
    .irq_req   (req_a),
    .irq_done  (done_a),
    .active_ch (ac_a),
    .bus       (bus_a)
  );

  vm_irq_ctrl #(.ACK_DELAY(3)) u_dut_b (
    .clk_p     (clk_p),
    .rst       (rst_b),
    .irq_req   (req_b),
    .irq_done  (done_b),
    .active_ch (ac_b),
    .bus       (bus_b)
  );

  always #5 clk_p = ~clk_p;

  typedef struct {
    logic        rst;
    logic        istb;
    logic [3:0]  req;
    logic        virq;
    logic        iack;
    logic [15:0] ivec;
    logic [3:0]  done;
    logic [2:0]  ac;
  } vec_t;

  function automatic vec_t mk(logic r, logic s, logic [3:0] q, logic v, logic a,
                              logic [15:0] iv, logic [3:0] d, logic [2:0] ac);
    vec_t t;
    t.rst = r; t.istb = s; t.req = q; t.virq = v; t.iack = a;
    t.ivec = iv; t.done = d; t.ac = ac;
    return t;
  endfunction

  task automatic step();
    @(posedge clk_p);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  vec_t tbl[33];

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    req_a = '0;   req_b = '0;
    bus_a.istb = 1'b0;
    bus_b.istb = 1'b0;

`ifndef IRQ_EDGE_EN
    //            rst  istb req      virq iack ivec     done     ac
    tbl[0]  = mk(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 16'o000, 4'b0000, 3'd0);
    tbl[1]  = mk(1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 16'o000, 4'b0000, 3'd0);
    tbl[2]  = mk(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 16'o000, 4'b0000, 3'd2);
    tbl[3]  = mk(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 16'o000, 4'b0000, 3'd2);
    tbl[4]  = mk(1'b0, 1'b1, 4'b0100, 1'b0, 1'b1, 16'o070, 4'b0000, 3'd2);
    tbl[5]  = mk(1'b0, 1'b1, 4'b0100, 1'b0, 1'b1, 16'o070, 4'b0000, 3'd2);
    tbl[6]  = mk(1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 16'o000, 4'b0100, 3'd2);
    tbl[7]  = mk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'o000, 4'b0000, 3'd2);
    tbl[8]  = mk(1'b0, 1'b0, 4'b1010, 1'b1, 1'b0, 16'o000, 4'b0000, 3'd2);
    tbl[9]  = mk(1'b0, 1'b1, 4'b1010, 1'b0, 1'b0, 16'o000, 4'b0000, 3'd1);
    // channel 1 withdraws after latch: still delivered and acknowledged
    tbl[10] = mk(1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 16'o000, 4'b0000, 3'd1);
    tbl[11] = mk(1'b0, 1'b1, 4'b1000, 1'b0, 1'b1, 16'o064, 4'b0000, 3'd1);
    tbl[12] = mk(1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 16'o000, 4'b0010, 3'd1);
    tbl[13] = mk(1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 16'o000, 4'b0000, 3'd1);
    tbl[14] = mk(1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 16'o000, 4'b0000, 3'd1);
    tbl[15] = mk(1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 16'o000, 4'b0000, 3'd3);
    // higher-priority channel appears after latch: winner stays frozen
    tbl[16] = mk(1'b0, 1'b1, 4'b1001, 1'b0, 1'b0, 16'o000, 4'b0000, 3'd3);
    tbl[17] = mk(1'b0, 1'b1, 4'b1001, 1'b0, 1'b1, 16'o104, 4'b0000, 3'd3);
    tbl[18] = mk(1'b0, 1'b0, 4'b1001, 1'b0, 1'b0, 16'o000, 4'b1000, 3'd3);
    tbl[19] = mk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'o000, 4'b0000, 3'd3);
    tbl[20] = mk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'o000, 4'b0000, 3'd3);
    // spurious
    tbl[21] = mk(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 16'o000, 4'b0000, 3'd0);
    tbl[22] = mk(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 16'o000, 4'b0000, 3'd0);
    tbl[23] = mk(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 16'o000, 4'b0000, 3'd0);
    tbl[24] = mk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'o000, 4'b0000, 3'd0);
    tbl[25] = mk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'o000, 4'b0000, 3'd0);
    // reset during DRIVE
    tbl[26] = mk(1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 16'o000, 4'b0000, 3'd0);
    tbl[27] = mk(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 16'o000, 4'b0000, 3'd2);
    tbl[28] = mk(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 16'o000, 4'b0000, 3'd2);
    tbl[29] = mk(1'b0, 1'b1, 4'b0100, 1'b0, 1'b1, 16'o070, 4'b0000, 3'd2);
    tbl[30] = mk(1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, 16'o000, 4'b0000, 3'd0);
    tbl[31] = mk(1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 16'o000, 4'b0000, 3'd0);
    tbl[32] = mk(1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 16'o000, 4'b0000, 3'd0);

    for (int k = 0; k < 33; k++) begin
      rst_a      = tbl[k].rst;
      bus_a.istb = tbl[k].istb;
      req_a      = tbl[k].req;
      step();
      chk($sformatf("row%0d virq", k), 32'(bus_a.virq), 32'(tbl[k].virq));
      chk($sformatf("row%0d iack", k), 32'(bus_a.iack), 32'(tbl[k].iack));
      chk($sformatf("row%0d ivec", k), 32'(bus_a.ivec), 32'(tbl[k].ivec));
      chk($sformatf("row%0d done", k), 32'(done_a),     32'(tbl[k].done));
      chk($sformatf("row%0d active_ch", k), 32'(ac_a),  32'(tbl[k].ac));
    end

    // ACK_DELAY=3 instance: abort in WAIT, then full-latency handshake.
    step();
    rst_b = 1'b0; req_b = 4'b0001;
    step();
    chk("b virq_after_req", 32'(bus_b.virq), 32'd1);
    bus_b.istb = 1'b1;
    step();
    chk("b virq_drop_on_latch", 32'(bus_b.virq), 32'd0);
    step();
    step();
    bus_b.istb = 1'b0;
    step();
    chk("b abort_iack", 32'(bus_b.iack), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("b abort_iack_c%0d", k), 32'(bus_b.iack), 32'd0);
      chk($sformatf("b abort_done_c%0d", k), 32'(done_b), 32'd0);
    end
    chk("b virq_after_abort", 32'(bus_b.virq), 32'd1);
    bus_b.istb = 1'b1;
    step();
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("b lat_iack_e%0d", k), 32'(bus_b.iack), 32'd0);
    end
    step();
    chk("b lat_iack_e4", 32'(bus_b.iack), 32'd1);
    chk("b lat_ivec_e4", 32'(bus_b.ivec), 32'(16'o060));
    bus_b.istb = 1'b0;
    step();
    chk("b done", 32'(done_b), 32'd1);
    chk("b ivec_zero", 32'(bus_b.ivec), 32'd0);
`else
    // Edge capture: one-cycle pulse on channel 2 is held pending.
    step();
    chk("e reset_virq", 32'(bus_a.virq), 32'd0);
    rst_a = 1'b0; req_a = 4'b0100;
    step();
    req_a = 4'b0000;
    step();
    chk("e virq_set", 32'(bus_a.virq), 32'd1);
    step();
    chk("e virq_held", 32'(bus_a.virq), 32'd1);
    bus_a.istb = 1'b1;
    step();
    chk("e active_ch", 32'(ac_a), 32'd2);
    step();
    step();
    chk("e iack", 32'(bus_a.iack), 32'd1);
    chk("e ivec", 32'(bus_a.ivec), 32'(16'o070));
    bus_a.istb = 1'b0;
    step();
    chk("e done", 32'(done_a), 32'b0100);
    step();
    chk("e done_clear", 32'(done_a), 32'd0);
    step();
    chk("e virq_cleared", 32'(bus_a.virq), 32'd0);
    step();
    chk("e virq_stays_low", 32'(bus_a.virq), 32'd0);
    chk("e b_idle_iack", 32'(bus_b.iack), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
